// File: rtl/pal_cycle_ctrl.sv
// Palette colour-cycling controller: remaps 3-bit pixels by a phase that advances on frame edges.
// Optional macro PAL_CYCLE_DIR_EN adds dir_i so advances can run the phase backwards.
module pal_cycle_ctrl #(
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vsync_i,
    input  logic       pause_i,
    input  logic       step_i,
`ifdef PAL_CYCLE_DIR_EN
    input  logic       dir_i,
`endif
    input  logic       de_i,
    input  logic [2:0] rgb_i,
    output logic [2:0] rgb_o,
    output logic       de_o,
    output logic [3:0] phase_o,
    output logic       tick_o
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);

    state_t     state, state_nxt;
    logic       vsync_q, step_q;
    logic       frame_edge, step_edge;
    logic       step_pend, step_pend_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] phase, phase_nxt;
    logic       adv, dec;

    // Colour 3 is fixed; {0,1,2,4} rotates with period 4 and {5,6,7} with period 3.
    function automatic logic [2:0] remap(input logic [2:0] c, input logic [3:0] ph);
        logic [1:0] i4;
        logic [2:0] i3;
        logic [2:0] r;
        i4 = 2'd0;
        i3 = 3'd0;
        r  = c;
        case (c)
            3'd0, 3'd1, 3'd2: begin
                i4 = c[1:0] + ph[1:0];
                r  = (i4 == 2'd3) ? 3'd4 : {1'b0, i4};
            end
            3'd4: begin
                i4 = 2'd3 + ph[1:0];
                r  = (i4 == 2'd3) ? 3'd4 : {1'b0, i4};
            end
            3'd5, 3'd6, 3'd7: begin
                i3 = (c - 3'd5) + 3'(ph % 4'd3);
                if (i3 >= 3'd3) i3 = i3 - 3'd3;
                r = 3'd5 + i3;
            end
            default: r = c;
        endcase
        return r;
    endfunction

`ifdef PAL_CYCLE_DIR_EN
    assign dec = dir_i;
`else
    assign dec = 1'b0;
`endif

    assign frame_edge = vsync_i & ~vsync_q;
    assign step_edge  = step_i & ~step_q;
    assign phase_o    = phase;

    always_comb begin
        state_nxt     = pause_i ? HOLD : RUN;
        cnt_nxt       = cnt;
        step_pend_nxt = step_pend;
        adv           = 1'b0;
        phase_nxt     = phase;
        if (state == RUN) begin
            step_pend_nxt = 1'b0;
            if (frame_edge) begin
                if (cnt == LAST) begin
                    cnt_nxt = 8'd0;
                    adv     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
        end else begin
            // The frame counter is frozen here so RUN resumes mid-count.
            if (frame_edge && step_pend) begin
                adv           = 1'b1;
                step_pend_nxt = 1'b0;
            end
            if (step_edge) step_pend_nxt = 1'b1;
            if (state_nxt == RUN) step_pend_nxt = 1'b0;
        end
        if (adv) begin
            if (dec) phase_nxt = (phase == 4'd0) ? 4'd11 : phase - 4'd1;
            else     phase_nxt = (phase == 4'd11) ? 4'd0 : phase + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            vsync_q   <= 1'b1;
            step_q    <= 1'b1;
            step_pend <= 1'b0;
            cnt       <= 8'd0;
            phase     <= 4'd0;
            tick_o    <= 1'b0;
            rgb_o     <= 3'd0;
            de_o      <= 1'b0;
        end else begin
            state     <= state_nxt;
            vsync_q   <= vsync_i;
            step_q    <= step_i;
            step_pend <= step_pend_nxt;
            cnt       <= cnt_nxt;
            phase     <= phase_nxt;
            tick_o    <= adv;
            rgb_o     <= remap(rgb_i, phase);
            de_o      <= de_i;
        end
    end
endmodule
